axi_req_sequencer: RTL

- Sequences single-beat AXI4 transactions on the core's one master port.
- Serves two requesters: IFU (read only) and LSU (read/write).
- Registered FSM: one outstanding transaction, fair grant, lane/strobe alignment, error reporting.
- Sits between IFU/LSU and the SoC AXI4 master interface.

---
 rtl/axi_req_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/axi_req_sequencer.sv
// Single-outstanding AXI4 request sequencer arbitrating IFU (read) and LSU (read/write) onto one master port.
// Optional watchdog: define AXI_ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module axi_req_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef AXI_ARB_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   input  logic [ADDR_W-1:0] ifu_req_addr,
   input  logic              lsu_req_valid,
   input  logic              lsu_req_write,
   input  logic [ADDR_W-1:0] lsu_req_addr,
   input  logic [DATA_W-1:0] lsu_req_wdata,
   input  logic [3:0]        lsu_req_wstrb,
   output logic              ifu_resp_valid,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic [ADDR_W-1:0] m_addr,
   output logic [2:0]        m_size,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic              m_rvalid,
   output logic              m_rready,
   input  logic [63:0]       m_rdata,
   input  logic [1:0]        m_rresp,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic              m_wvalid,
   input  logic              m_wready,
   output logic [63:0]       m_wdata,
   output logic [7:0]        m_wstrb,
   input  logic              m_bvalid,
   output logic              m_bready,
   input  logic [1:0]        m_bresp
);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_t;

   state_t            r_state;
   logic              r_pend;
   logic              r_id_lsu;
   logic              r_aw_done;
   logic              r_w_done;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_size;
   logic [63:0]       r_wdata;
   logic [7:0]        r_wstrb;
   logic [DATA_W-1:0] r_resp_data;
   logic              r_resp_err;

   function automatic logic [2:0] size_of(input logic [3:0] strb);
      case (strb)
         4'b0001: size_of = 3'd0;
         4'b0011: size_of = 3'd1;
         4'b1111: size_of = 3'd2;
         default: size_of = 3'd0;
      endcase
   endfunction

   // LSU has priority unless the IFU was passed over on the previous LSU grant
   logic              w_gnt_lsu;
   logic              w_gnt_any;
   logic              w_sel_write;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [3:0]        w_sel_strb;
   logic [3:0]        w_lane_strb;
   logic [31:0]       w_word;
   logic [31:0]       w_half;
   logic [31:0]       w_rword;
   logic              w_aw_w_done;

   assign w_gnt_lsu   = lsu_req_valid && !(ifu_req_valid && r_pend);
   assign w_gnt_any   = lsu_req_valid || ifu_req_valid;
   assign w_sel_write = w_gnt_lsu && lsu_req_write;
   assign w_sel_addr  = w_gnt_lsu ? lsu_req_addr : ifu_req_addr;
   assign w_sel_strb  = w_gnt_lsu ? lsu_req_wstrb : 4'b1111;
   assign w_lane_strb = w_sel_strb << w_sel_addr[1:0];
   assign w_word      = lsu_req_wdata[31:0] << {w_sel_addr[1:0], 3'b000};
   assign w_half      = r_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
   assign w_rword     = w_half >> {r_addr[1:0], 3'b000};
   assign w_aw_w_done = (r_aw_done || m_awready) && (r_w_done || m_wready);

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_tmo_cnt;
   logic             w_timed;
   logic             w_leave;
   logic             w_tmo;

   assign w_timed = (r_state == S_AR) || (r_state == S_R) ||
                    (r_state == S_AW_W) || (r_state == S_B);
   assign w_leave = ((r_state == S_AR) && m_arready) || ((r_state == S_R) && m_rvalid) ||
                    ((r_state == S_AW_W) && w_aw_w_done) || ((r_state == S_B) && m_bvalid);
   assign w_tmo   = w_timed && !w_leave && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts cycles spent in the current wait state; restarts on every state entry
   always_ff @(posedge clk) begin
      if (rst || !w_timed || w_leave) r_tmo_cnt <= '0;
      else                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pend      <= 1'b0;
         r_id_lsu    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_addr      <= '0;
         r_size      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_resp_data <= '0;
         r_resp_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_any) begin
                  r_pend    <= w_gnt_lsu ? ifu_req_valid : 1'b0;
                  r_id_lsu  <= w_gnt_lsu;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_addr    <= w_sel_addr;
                  r_size    <= size_of(w_sel_strb);
                  r_wdata   <= w_sel_write ? {w_word, w_word} : 64'd0;
                  r_wstrb   <= w_sel_write ? (w_sel_addr[2] ? {w_lane_strb, 4'b0000}
                                                            : {4'b0000, w_lane_strb}) : 8'd0;
                  r_state   <= w_sel_write ? S_AW_W : S_AR;
               end
            end
            S_AR: if (m_arready) r_state <= S_R;
            S_R: begin
               if (m_rvalid) begin
                  r_resp_data <= DATA_W'(w_rword);
                  r_resp_err  <= |m_rresp;
                  r_state     <= S_RESP;
               end
            end
            S_AW_W: begin
               if (m_awready)   r_aw_done <= 1'b1;
               if (m_wready)    r_w_done  <= 1'b1;
               if (w_aw_w_done) r_state   <= S_B;
            end
            S_B: begin
               if (m_bvalid) begin
                  r_resp_data <= '0;
                  r_resp_err  <= |m_bresp;
                  r_state     <= S_RESP;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
`ifdef AXI_ARB_TIMEOUT_EN
         if (w_tmo) begin
            r_state     <= S_RESP;
            r_resp_err  <= 1'b1;
            r_resp_data <= '0;
         end
`endif
      end
   end

   assign m_arvalid      = (r_state == S_AR);
   assign m_rready       = (r_state == S_R);
   assign m_awvalid      = (r_state == S_AW_W) && !r_aw_done;
   assign m_wvalid       = (r_state == S_AW_W) && !r_w_done;
   assign m_bready       = (r_state == S_B);
   assign ifu_resp_valid = (r_state == S_RESP) && !r_id_lsu;
   assign lsu_resp_valid = (r_state == S_RESP) && r_id_lsu;
   assign m_addr         = r_addr;
   assign m_size         = r_size;
   assign m_wdata        = r_wdata;
   assign m_wstrb        = r_wstrb;
   assign resp_data      = r_resp_data;
   assign resp_err       = r_resp_err;

endmodule
